// File: rtl/alu_pkg.sv
// Shared types, widths and helpers for the ALU command sequencer.
package alu_pkg;

    localparam int OPCODE_WIDTH = 2;
    localparam int DATA_WIDTH   = 31;
    localparam int TAG_WIDTH    = 3;
    localparam int FIFO_DEPTH   = 4;
    localparam int COUNT_WIDTH  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [OPCODE_WIDTH:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_INC = 3'd2,
        OP_DEC = 3'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } seq_state_e;

    typedef struct packed {
        logic [OPCODE_WIDTH:0] opcode;
        logic [DATA_WIDTH:0]   op1;
        logic [DATA_WIDTH:0]   op2;
        logic [TAG_WIDTH:0]    tag;
    } alu_req_t;

    // Only the four arithmetic opcodes may ever reach the ALU.
    function automatic logic is_legal_op(input logic [OPCODE_WIDTH:0] op);
        return op inside {OP_ADD, OP_SUB, OP_INC, OP_DEC};
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request and response valid/ready channels of the ALU command sequencer.
interface alu_req_if;
    import alu_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [OPCODE_WIDTH:0] opcode;
    logic [DATA_WIDTH:0]   op1;
    logic [DATA_WIDTH:0]   op2;
    logic [TAG_WIDTH:0]    tag;

    modport master (output valid, opcode, op1, op2, tag, input ready);
    modport slave  (input valid, opcode, op1, op2, tag, output ready);
endinterface

interface alu_rsp_if;
    import alu_pkg::*;

    logic                valid;
    logic                ready;
    logic [DATA_WIDTH:0] result;
    logic                carry;
    logic                zero;
    logic                err;
    logic [TAG_WIDTH:0]  tag;

    modport master (output valid, result, carry, zero, err, tag, input ready);
    modport slave  (input valid, result, carry, zero, err, tag, output ready);
endinterface

// File: rtl/alu_req_fifo.sv
// Small synchronous FIFO buffering requests ahead of the sequencer FSM.
// Full/empty come straight from the registered occupancy count.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_pushData,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_popData,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_popData = r_mem[r_rdPtr];
    assign w_doPush  = i_push && !o_full;
    assign w_doPop   = i_pop && !o_empty;

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// Command front-end for the registered 32-bit ALU: queues requests, issues
// one legal operation at a time, and returns tagged responses. Illegal
// opcodes are answered with err=1 without ever touching the ALU inputs.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    alu_req_if.slave               req,
    alu_rsp_if.master              rsp,
    output logic [OPCODE_WIDTH:0]  alu_opcode,
    output logic [DATA_WIDTH:0]    alu_op1,
    output logic [DATA_WIDTH:0]    alu_op2,
    input  logic [DATA_WIDTH:0]    alu_result,
    input  logic                   alu_carry,
    input  logic                   alu_zero,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] fifo_count
);
    seq_state_e            r_state;
    logic [OPCODE_WIDTH:0] r_aluOpcode;
    logic [DATA_WIDTH:0]   r_aluOp1;
    logic [DATA_WIDTH:0]   r_aluOp2;
    logic [TAG_WIDTH:0]    r_tag;
    logic                  r_rspValid;
    logic [DATA_WIDTH:0]   r_rspResult;
    logic                  r_rspCarry;
    logic                  r_rspZero;
    logic                  r_rspErr;
    logic [TAG_WIDTH:0]    r_rspTag;

    alu_req_t w_pushReq;
    alu_req_t w_head;
    logic     w_push;
    logic     w_pop;
    logic     w_full;
    logic     w_empty;
    logic     w_headLegal;

    assign w_pushReq   = '{opcode: req.opcode, op1: req.op1, op2: req.op2, tag: req.tag};
    assign w_push      = req.valid && !w_full;
    assign w_pop       = !w_empty && ((r_state == IDLE) || ((r_state == RESP) && rsp.ready));
    assign w_headLegal = is_legal_op(w_head.opcode);

    alu_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(alu_req_t))
    ) u_reqFifo (
        .clk        (clk),
        .rstn       (rstn),
        .i_push     (w_push),
        .i_pushData (w_pushReq),
        .i_pop      (w_pop),
        .o_popData  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (fifo_count)
    );

    // Sequencer FSM; a pop (from IDLE or a completed RESP) overrides the
    // default next state so back-to-back ops skip IDLE entirely.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_aluOpcode <= '0;
            r_aluOp1    <= '0;
            r_aluOp2    <= '0;
            r_tag       <= '0;
            r_rspValid  <= 1'b0;
            r_rspResult <= '0;
            r_rspCarry  <= 1'b0;
            r_rspZero   <= 1'b0;
            r_rspErr    <= 1'b0;
            r_rspTag    <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= IDLE;
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    r_rspResult <= alu_result;
                    r_rspCarry  <= alu_carry;
                    r_rspZero   <= alu_zero;
                    r_rspErr    <= 1'b0;
                    r_rspTag    <= r_tag;
                    r_rspValid  <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp.ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_pop) begin
                if (w_headLegal) begin
                    r_aluOpcode <= w_head.opcode;
                    r_aluOp1    <= w_head.op1;
                    r_aluOp2    <= w_head.op2;
                    r_tag       <= w_head.tag;
                    r_state     <= ISSUE;
                end else begin
                    r_rspResult <= '0;
                    r_rspCarry  <= 1'b0;
                    r_rspZero   <= 1'b0;
                    r_rspErr    <= 1'b1;
                    r_rspTag    <= w_head.tag;
                    r_rspValid  <= 1'b1;
                    r_state     <= RESP;
                end
            end
        end
    end

    assign req.ready  = !w_full;
    assign rsp.valid  = r_rspValid;
    assign rsp.result = r_rspResult;
    assign rsp.carry  = r_rspCarry;
    assign rsp.zero   = r_rspZero;
    assign rsp.err    = r_rspErr;
    assign rsp.tag    = r_rspTag;
    assign alu_opcode = r_aluOpcode;
    assign alu_op1    = r_aluOp1;
    assign alu_op2    = r_aluOp2;
    assign busy       = (r_state != IDLE) || !w_empty;
endmodule
